// File: rtl/hack_screen_scanner_if.sv
// rtl/hack_screen_scanner_if.sv - screen RAM read port and pixel stream bundle
interface hack_screen_scanner_if #(
    parameter int ADDR_W = 13
) ();
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_eof;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rdata,
        output pix_valid, pix, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rdata,
        input  pix_valid, pix, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/hack_screen_scanner.sv
// rtl/hack_screen_scanner.sv - raster-order screen RAM reader serialising words to a pixel stream
module hack_screen_scanner #(
    parameter int ROWS          = 256,
    parameter int WORDS_PER_ROW = 32,
    parameter int ADDR_W        = 13
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic busy,
    hack_screen_scanner_if.master bus
);
    localparam int TOTAL = ROWS * WORDS_PER_ROW;
    localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0] r_word_cnt;
    logic [COL_W-1:0]  r_col;
    logic              r_words_left;
    logic              r_pending, r_pend_sof, r_pend_eol, r_pend_eof;
    logic [15:0]       r_pf_data;
    logic              r_pf_full, r_pf_sof, r_pf_eol, r_pf_eof;
    logic [15:0]       r_sh_data;
    logic              r_sh_full, r_sh_sof, r_sh_eol, r_sh_eof;
    logic [3:0]        r_bit_cnt;

    logic w_run, w_xfer, w_last_xfer, w_frame_end, w_stop;
    logic w_sh_load, w_next_ok, w_req, w_issue, w_last_word, w_last_col;

    assign w_run       = (r_state == S_RUN);
    assign w_xfer      = r_sh_full && bus.pix_ready;
    assign w_last_xfer = w_xfer && (r_bit_cnt == 4'hF);
    assign w_frame_end = w_last_xfer && r_sh_eof;
    assign w_stop      = w_frame_end && !enable;
    assign w_sh_load   = r_pf_full && (!r_sh_full || w_last_xfer);
    // While the eof word sits in the shifter, any fetch belongs to the next
    // frame and is only worth issuing if the frame will actually continue.
    assign w_next_ok   = !(r_sh_full && r_sh_eof) || enable;
    assign w_req       = w_run && r_words_left && !r_pending
                         && (!r_pf_full || w_sh_load) && w_next_ok;
    assign w_issue     = w_req && bus.mem_gnt;
    assign w_last_word = (r_word_cnt == ADDR_W'(TOTAL - 1));
    assign w_last_col  = (r_col == COL_W'(WORDS_PER_ROW - 1));

    assign bus.mem_req   = w_req;
    assign bus.mem_addr  = r_word_cnt;
    assign bus.pix_valid = r_sh_full;
    assign bus.pix       = r_sh_data[0];
    assign bus.pix_sof   = r_sh_full && r_sh_sof && (r_bit_cnt == 4'h0);
    assign bus.pix_eol   = r_sh_full && r_sh_eol && (r_bit_cnt == 4'hF);
    assign bus.pix_eof   = r_sh_full && r_sh_eof && (r_bit_cnt == 4'hF);
    assign busy          = w_run;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_state_nxt = S_RUN;
            S_RUN:   if (w_stop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_word_cnt   <= '0;
            r_col        <= '0;
            r_words_left <= 1'b0;
            r_pending    <= 1'b0;
            r_pend_sof   <= 1'b0;
            r_pend_eol   <= 1'b0;
            r_pend_eof   <= 1'b0;
            r_pf_data    <= '0;
            r_pf_full    <= 1'b0;
            r_pf_sof     <= 1'b0;
            r_pf_eol     <= 1'b0;
            r_pf_eof     <= 1'b0;
            r_sh_data    <= '0;
            r_sh_full    <= 1'b0;
            r_sh_sof     <= 1'b0;
            r_sh_eol     <= 1'b0;
            r_sh_eof     <= 1'b0;
            r_bit_cnt    <= '0;
        end else if (!w_run || w_stop) begin
            // Idle (or leaving for idle): drop any speculative next-frame fetch.
            r_word_cnt   <= '0;
            r_col        <= '0;
            r_words_left <= 1'b1;
            r_pending    <= 1'b0;
            r_pend_sof   <= 1'b0;
            r_pend_eol   <= 1'b0;
            r_pend_eof   <= 1'b0;
            r_pf_data    <= '0;
            r_pf_full    <= 1'b0;
            r_pf_sof     <= 1'b0;
            r_pf_eol     <= 1'b0;
            r_pf_eof     <= 1'b0;
            r_sh_data    <= '0;
            r_sh_full    <= 1'b0;
            r_sh_sof     <= 1'b0;
            r_sh_eol     <= 1'b0;
            r_sh_eof     <= 1'b0;
            r_bit_cnt    <= '0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_pend_sof <= (r_word_cnt == '0);
                r_pend_eol <= w_last_col;
                r_pend_eof <= w_last_word;
                if (w_last_word) begin
                    r_word_cnt   <= '0;
                    r_col        <= '0;
                    r_words_left <= 1'b0;
                end else begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_col      <= w_last_col ? '0 : r_col + 1'b1;
                end
            end
            if (w_sh_load && r_pf_eof) begin
                r_words_left <= 1'b1;
            end

            if (r_pending) begin
                r_pf_full <= 1'b1;
                r_pf_data <= bus.mem_rdata;
                r_pf_sof  <= r_pend_sof;
                r_pf_eol  <= r_pend_eol;
                r_pf_eof  <= r_pend_eof;
            end else if (w_sh_load) begin
                r_pf_full <= 1'b0;
            end

            if (w_sh_load) begin
                r_sh_data <= r_pf_data;
                r_sh_full <= 1'b1;
                r_sh_sof  <= r_pf_sof;
                r_sh_eol  <= r_pf_eol;
                r_sh_eof  <= r_pf_eof;
                r_bit_cnt <= '0;
            end else if (w_xfer) begin
                r_sh_data <= {1'b0, r_sh_data[15:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == 4'hF) begin
                    r_sh_full <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_hack_screen_scanner.sv
// tb/tb_hack_screen_scanner.sv - self-checking bench for hack_screen_scanner
module tb_hack_screen_scanner;
    localparam int ROWS     = 4;
    localparam int WPR      = 2;
    localparam int AW       = 4;
    localparam int NW       = ROWS * WPR;
    localparam int FRAME_PX = NW * 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;
    logic busy;

    hack_screen_scanner_if #(.ADDR_W(AW)) bus ();

    hack_screen_scanner #(.ROWS(ROWS), .WORDS_PER_ROW(WPR), .ADDR_W(AW)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [15:0] ram [0:(1<<AW)-1];

    // Single-cycle-latency RAM; data is junk except the cycle after an issue.
    always @(posedge clock) begin
        if (bus.mem_req && bus.mem_gnt) bus.mem_rdata <= ram[bus.mem_addr];
        else                            bus.mem_rdata <= 16'hDEAD;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit rdy_rand = 1'b0;
    int gnt_hold = 0;

    initial begin
        bus.pix_ready = 1'b1;
        bus.mem_gnt   = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            bus.pix_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (gnt_hold > 0) begin
                bus.mem_gnt = 1'b0;
                gnt_hold--;
            end else begin
                bus.mem_gnt = 1'b1;
            end
        end
    end

    // Expected {pix, sof, eol, eof} for pixel q of a frame in raster order.
    function automatic logic [3:0] model(input int q);
        int w, b;
        w = q / 16;
        b = q % 16;
        model = {ram[w][b], q == 0, (b == 15) && (w % WPR == WPR - 1), q == FRAME_PX - 1};
    endfunction

    int p = 0, cyc = 0;
    int n_xfer = 0, n_eol = 0, n_eof = 0, n_sof = 0;
    int last_eof_cyc = -1, last_gap = -1;
    logic px30 = 1'b0, px31 = 1'b0;
    logic prev_stall = 1'b0, prev_wait = 1'b0, prev_issue = 1'b0, issue;
    logic [3:0] prev_bits = '0, cur;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            p = 0;
            prev_stall = 1'b0;
            prev_wait = 1'b0;
            prev_issue = 1'b0;
            last_eof_cyc = -1;
        end else begin
            cur = {bus.pix, bus.pix_sof, bus.pix_eol, bus.pix_eof};
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.pix_valid), 1);
                chk("stall_hold", 32'(cur), 32'(prev_bits));
            end
            if (prev_wait) begin
                chk("req_hold", 32'(bus.mem_req), 1);
                chk("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
            end
            issue = bus.mem_req && bus.mem_gnt;
            chk("one_outstanding", 32'(prev_issue && issue), 0);
            if (bus.pix_valid) chk("busy_with_valid", 32'(busy), 1);
            if (bus.pix_valid && bus.pix_ready) begin
                chk("pixel", 32'(cur), 32'(model(p)));
                n_xfer++;
                if (bus.pix_eol) n_eol++;
                if (bus.pix_eof) n_eof++;
                if (bus.pix_sof) n_sof++;
                if (p == 30) px30 = bus.pix;
                if (p == 31) px31 = bus.pix;
                if (bus.pix_sof && last_eof_cyc >= 0) last_gap = cyc - last_eof_cyc;
                if (bus.pix_eof) last_eof_cyc = cyc;
                p = (p + 1) % FRAME_PX;
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_bits  = cur;
            prev_wait  = bus.mem_req && !bus.mem_gnt;
            prev_addr  = bus.mem_addr;
            prev_issue = issue;
        end
    end

    task automatic pulse_enable();
        @(posedge clock); #1 enable = 1'b1;
        @(posedge clock); #1 enable = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin @(negedge clock); n++; end
        chk("idle_timeout", 32'(n < 3000), 1);
    endtask

    task automatic wait_pix(input int target);
        int n = 0;
        while (p < target && n < 3000) begin @(negedge clock); n++; end
        chk("pix_timeout", 32'(n < 3000), 1);
    endtask

    int x0, e0, l0, s0, k;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 16'h0000;
        ram[0] = 16'h0001;
        ram[1] = 16'h8000;

        // Reset with enable high: everything quiet.
        enable = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_valid", 32'(bus.pix_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_marks", 32'({bus.pix, bus.pix_sof, bus.pix_eol, bus.pix_eof}), 0);
        enable = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("idle_req", 32'(bus.mem_req), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // Single frame, latency and markers.
        x0 = n_xfer; e0 = n_eof; l0 = n_eol; s0 = n_sof;
        @(posedge clock); #1 enable = 1'b1;
        @(posedge clock); #1 enable = 1'b0;
        k = 0;
        @(negedge clock);
        while (!bus.pix_valid && k < 20) begin @(posedge clock); k++; @(negedge clock); end
        chk("latency", 32'(k), 3);
        chk("first_pix_sof", 32'({bus.pix, bus.pix_sof}), 32'h3);
        wait_idle();
        chk("f1_xfers", 32'(n_xfer - x0), FRAME_PX);
        chk("f1_eols", 32'(n_eol - l0), ROWS);
        chk("f1_eofs", 32'(n_eof - e0), 1);
        chk("f1_sofs", 32'(n_sof - s0), 1);
        chk("f1_busy", 32'(busy), 0);
        chk("px31", 32'(px31), 1);
        chk("px30", 32'(px30), 0);

        // Random backpressure.
        for (int i = 0; i < NW; i++) ram[i] = {4'(i), 4'(~i), 4'(i + 3), 4'(i)};
        rdy_rand = 1'b1;
        x0 = n_xfer; e0 = n_eof;
        pulse_enable();
        wait_idle();
        chk("bp_xfers", 32'(n_xfer - x0), FRAME_PX);
        chk("bp_eofs", 32'(n_eof - e0), 1);
        rdy_rand = 1'b0;

        // Grant stall mid-row.
        for (int i = 0; i < NW; i++) ram[i] = 16'hC3A5 ^ 16'(i * 16'h1111);
        x0 = n_xfer;
        pulse_enable();
        wait_pix(20);
        gnt_hold = 40;
        wait_idle();
        chk("gs_xfers", 32'(n_xfer - x0), FRAME_PX);

        // Two continuous frames, then enable drops mid second frame.
        x0 = n_xfer; e0 = n_eof;
        @(posedge clock); #1 enable = 1'b1;
        k = 0;
        while (n_eof < e0 + 1 && k < 3000) begin @(negedge clock); k++; end
        chk("cont_eof_timeout", 32'(k < 3000), 1);
        wait_pix(40);
        chk("cont_gap_ok", 32'(last_gap >= 1 && last_gap <= 4), 1);
        @(posedge clock); #1 enable = 1'b0;
        wait_idle();
        chk("cont_eofs", 32'(n_eof - e0), 2);
        chk("cont_xfers", 32'(n_xfer - x0), 2 * FRAME_PX);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stop_req", 32'(bus.mem_req), 0);
            chk("stop_valid", 32'(bus.pix_valid), 0);
        end

        // Reset in the middle of a frame, then restart.
        @(posedge clock); #1 enable = 1'b1;
        wait_pix(50);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.pix_valid), 0);
        chk("mid_rst_req", 32'(bus.mem_req), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 0);
        chk("mid_rst_marks", 32'({bus.pix, bus.pix_sof, bus.pix_eol, bus.pix_eof}), 0);
        @(negedge clock);
        @(posedge clock); #1 reset_n = 1'b1;
        k = 0;
        @(negedge clock);
        while (!bus.mem_req && k < 20) begin @(negedge clock); k++; end
        chk("restart_addr", 32'(bus.mem_addr), 0);
        enable = 1'b0;
        k = 0;
        while (!bus.pix_valid && k < 20) begin @(negedge clock); k++; end
        chk("restart_sof", 32'(bus.pix_sof), 1);
        x0 = n_xfer;
        wait_idle();
        chk("restart_xfers", 32'(n_xfer - x0), FRAME_PX);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
